// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file: address
// validity and the fixed port-priority write select.
package regfile_pkg;

  localparam int REGFILE_DATA_W = 16;
  localparam int REGFILE_DEPTH  = 8;

  typedef enum logic [1:0] {
    WSEL_NONE = 2'd0,
    WSEL_P0   = 2'd1,
    WSEL_P1   = 2'd2
  } wsel_e;

  function automatic logic addr_valid(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

  // Port 1 wins when both write ports hit the same register.
  function automatic wsel_e wr_sel(input logic hit_0, input logic hit_1);
    if (hit_1) return WSEL_P1;
    if (hit_0) return WSEL_P0;
    return WSEL_NONE;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write busy bits: decode reserves a destination, any write-back
// to that register releases it; a same-cycle reserve beats the release.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH   = REGFILE_DEPTH,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter bit R0_ZERO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_0,
  input  logic [ADDR_W-1:0] wr_addr_0,
  input  logic              wr_en_1,
  input  logic [ADDR_W-1:0] wr_addr_1,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [DEPTH-1:0]  busy_vec
);

  logic [DEPTH-1:0] r_busy;

  // Out-of-range addresses never match any n, so they are ignored for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      for (int n = 0; n < DEPTH; n++) begin
        if (R0_ZERO && n == 0) begin
          r_busy[n] <= 1'b0;
        end else if (rsv_en && rsv_addr == ADDR_W'(n)) begin
          r_busy[n] <= 1'b1;
        end else if ((wr_en_0 && wr_addr_0 == ADDR_W'(n)) ||
                     (wr_en_1 && wr_addr_1 == ADDR_W'(n))) begin
          r_busy[n] <= 1'b0;
        end
      end
    end
  end

  assign busy_vec = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Flop-based register file: two async read ports with optional write bypass,
// two prioritised write ports, and a per-register pending-write scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int                DATA_W   = REGFILE_DATA_W,
  parameter int                DEPTH    = REGFILE_DEPTH,
  parameter int                ADDR_W   = $clog2(DEPTH),
  parameter bit                BYPASS   = 1'b1,
  parameter bit                R0_ZERO  = 1'b0,
  parameter logic [DATA_W-1:0] R0_RESET = DATA_W'(16'h0001)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  input  logic              wr_en_0,
  input  logic [ADDR_W-1:0] wr_addr_0,
  input  logic [DATA_W-1:0] wr_data_0,
  input  logic              wr_en_1,
  input  logic [ADDR_W-1:0] wr_addr_1,
  input  logic [DATA_W-1:0] wr_data_1,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [DEPTH-1:0]  busy_vec
);

  localparam logic [DATA_W-1:0] R0_INIT = R0_ZERO ? '0 : R0_RESET;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  w_busy_vec;

  regfile_scoreboard #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .R0_ZERO (R0_ZERO)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_0   (wr_en_0),
    .wr_addr_0 (wr_addr_0),
    .wr_en_1   (wr_en_1),
    .wr_addr_1 (wr_addr_1),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .busy_vec  (w_busy_vec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < DEPTH; n++) begin
        r_regs[n] <= (n == 0) ? R0_INIT : '0;
      end
    end else begin
      for (int n = 0; n < DEPTH; n++) begin
        if (!(R0_ZERO && n == 0)) begin
          case (wr_sel(wr_en_0 && wr_addr_0 == ADDR_W'(n),
                       wr_en_1 && wr_addr_1 == ADDR_W'(n)))
            WSEL_P1: r_regs[n] <= wr_data_1;
            WSEL_P0: r_regs[n] <= wr_data_0;
            default: r_regs[n] <= r_regs[n];
          endcase
        end
      end
    end
  end

  // No handshake anywhere: every read, write and reserve is taken each cycle.
  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_busy;
    wsel_e             w_sel;

    assign w_addr = (p == 0) ? rd_addr_a : rd_addr_b;

    always_comb begin
      w_data = '0;
      w_busy = 1'b0;
      w_sel  = wr_sel(wr_en_0 && wr_addr_0 == w_addr, wr_en_1 && wr_addr_1 == w_addr);
      if (addr_valid(32'(w_addr), DEPTH) && !(R0_ZERO && w_addr == '0)) begin
        w_data = r_regs[w_addr];
        w_busy = w_busy_vec[w_addr];
        // A same-cycle reserve keeps the stored busy instead of the early release.
        if (BYPASS && w_sel != WSEL_NONE) begin
          w_data = (w_sel == WSEL_P1) ? wr_data_1 : wr_data_0;
          w_busy = (rsv_en && rsv_addr == w_addr) ? w_busy_vec[w_addr] : 1'b0;
        end
      end
    end
  end

  assign rd_data_a = g_rd[0].w_data;
  assign rd_busy_a = g_rd[0].w_busy;
  assign rd_data_b = g_rd[1].w_data;
  assign rd_busy_b = g_rd[1].w_busy;
  assign busy_vec  = w_busy_vec;

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file with a per-register pending-write scoreboard, replacing the fixed 8×16, 2-read/1-write register file in the CPU datapath. Two asynchronous read ports, two synchronous write ports with fixed priority, optional write-to-read bypass, and a busy bit per register. Decode reserves a destination, and write-back releases it. Sits between decode (read/reserve) and write-back (write/release).

## Interface
- DATA_W, 16: register width in bits.
- DEPTH, 8: number of registers, 2..64, need not be a power of two.
- ADDR_W, $clog2(DEPTH): address width.
- BYPASS, 1: 1 means a same-cycle write is forwarded to the read data and busy outputs. 0 means reads show the stored value only.
- R0_ZERO, 0: 1 means register 0 always reads 0, ignores writes and never becomes busy.
- R0_RESET, 16'h0001: reset value of register 0 when R0_ZERO=0, truncated to DATA_W.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous and active-low.
- rd_addr_a, rd_addr_b  in  ADDR_W  read addresses.
- rd_data_a, rd_data_b  out  DATA_W  read data, combinational.
- rd_busy_a, rd_busy_b  out  1  pending-write flag of the addressed register.
- wr_en_0, wr_en_1  in  1  write enables. Port 1 has priority.
- wr_addr_0, wr_addr_1  in  ADDR_W  write addresses.
- wr_data_0, wr_data_1  in  DATA_W  write data.
- rsv_en  in  1  reserve a destination register (sets busy).
- rsv_addr  in  ADDR_W  register to reserve.
- busy_vec  out  DEPTH  all busy bits, registered.

## Operation
**Storage**
- DEPTH×DATA_W flops, not RAM, so that asynchronous reset works.

**Writes**
- A write with wr_en_x=1 updates the register on the clock edge.
- If both ports target the same address, port 1's data is stored and port 0 is dropped.

**Busy release**
- Any write to address N clears busy[N] at the edge, even when that port's data is dropped.

**Reserve**
- rsv_en sets busy[rsv_addr] at the edge.
- A reserve and a write to the same address in one cycle leave busy=1. The reservation belongs to the younger instruction.
- Reserving an already-busy register keeps it busy. There is no count.

**Reads**
- rd_data_x = reg[rd_addr_x].
- rd_busy_x = busy[rd_addr_x].
- With BYPASS=1 and an active write to rd_addr_x this cycle:
  - rd_data_x returns the winning write data.
  - rd_busy_x returns 0, unless rsv_en targets the same address.
- Reserve has no bypass effect on rd_busy in the cycle it is asserted.

**Register 0 with R0_ZERO=1**
- Reads of address 0 return 0 and rd_busy=0, including under bypass.
- Writes and reserves to address 0 are ignored.
- busy_vec[0]=0.

**Out-of-range addresses (≥ DEPTH)**
- Reads return 0 with busy 0.
- Writes and reserves are ignored.
- No X is ever propagated.

## Timing
**Reset**
- rst_n low clears all registers to 0, except register 0, which takes R0_RESET (or 0 when R0_ZERO=1).
- All busy bits clear.
- Read outputs therefore show the reset values combinationally while reset is asserted.
- Reset takes effect immediately, regardless of clk.

**Reset mid-operation**
- Writes and reserves in the cycle where reset asserts are lost.
- Release is synchronous: the first write is accepted on the first rising edge with rst_n high.

**Latency**
- Write to read, no bypass: the new value is visible after the edge (1 cycle).
- Write to read, BYPASS=1: 0 cycles.
- Reserve to busy visible: 1 cycle.
- Write to busy cleared: 1 cycle, or 0 cycles on rd_busy when BYPASS=1.

**Flow control**
- No handshakes. Every request is accepted every cycle.

## Structure
**Package regfile_pkg**
- Default DATA_W and DEPTH.
- A function for address validity (addr < DEPTH).
- The port-priority write-select function shared by storage and bypass.

**Sub-module regfile_scoreboard**
- Holds the busy bits and the set/clear/priority logic.
- Ports: clk, rst_n, the two write enables/addresses, rsv_en/rsv_addr, busy_vec.
- The top level instantiates it once and does read muxing plus bypass.

## Test plan
1. **Reset:** assert rst_n=0 mid-write with defaults. Expect reg0 reads 16'h0001, reg1..7 read 0, busy_vec=8'h00 immediately.
2. **Write conflict:** wr_en_0=wr_en_1=1, both to addr 3, data 16'hAAAA and 16'h5555. Expect next cycle rd_data_a(3)=16'h5555. With BYPASS=1, expect 16'h5555 in the same cycle.
3. **Scoreboard:**
   - rsv addr 5, then a later write to 5 with 16'h1234 → busy_vec[5] goes 1 then 0, and reads return 16'h1234.
   - A simultaneous rsv+write on addr 5 → busy_vec[5] stays 1.
4. **BYPASS=0:** write 16'hBEEF to addr 2 and read addr 2 in the same cycle. Expect the old value 0, then 16'hBEEF next cycle.
5. **R0_ZERO=1:** write 16'hFFFF and reserve addr 0. Expect rd_data=0, rd_busy=0, busy_vec[0]=0 always.
6. **DEPTH=6:** write and reserve addr 7 with 16'h7777. Expect reads of addr 7 return 0, no busy bit set, registers 0..5 unchanged.
